// File: rtl/mult_mem_engine.sv
// mult_mem_engine
// Multiplies accepted operand pairs through a short pipeline and logs each
// product to consecutive addresses of a two-port memory (port B, wrapping
// write pointer). A block-read request streams a window of stored products
// back out through port A.

module mult_mem_engine #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 16,
    parameter int ADDR_W      = 6,
    parameter int MULT_STAGES = 2,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN_mult,
    input  logic [IN_W-1:0]   mult_input0,
    input  logic [IN_W-1:0]   mult_input1,
    input  logic              mode_sat,
    output logic              RDY_mult,
    output logic              EN_writeMem,
    output logic [ADDR_W-1:0] writeMem_addr,
    output logic [OUT_W-1:0]  writeMem_val,
    input  logic              EN_blockRead,
    input  logic [ADDR_W-1:0] blockRead_start,
    input  logic [ADDR_W:0]   blockRead_len,
    output logic              EN_readMem,
    output logic [ADDR_W-1:0] readMem_addr,
    input  logic [OUT_W-1:0]  readMem_val,
    output logic              VALID_memVal,
    output logic [OUT_W-1:0]  memVal_data,
    output logic              LAST_memVal,
    output logic [ADDR_W-1:0] wr_ptr
);

    localparam int PROD_W = 2 * IN_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE_LEN   = (ADDR_W+1)'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_WR = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]              state;
    logic                    readyArm;
    logic [ADDR_W-1:0]       startAddr;
    logic [ADDR_W:0]         lenReg;
    logic [ADDR_W:0]         remaining;
    logic                    issueLast;
    logic [READ_LAT-1:0]     validPipe;
    logic [READ_LAT-1:0]     lastPipe;

    logic [MULT_STAGES-1:0]  stageValid;
    logic [OUT_W-1:0]        stageData [MULT_STAGES];
    logic [ADDR_W-1:0]       stageAddr [MULT_STAGES];

    logic                    acceptPair;
    logic                    writesInFlight;
    logic [ADDR_W:0]         clampedLen;
    logic [PROD_W-1:0]       fullProduct;
    logic [OUT_W-1:0]        storedValue;

    assign RDY_mult       = readyArm && (state == IDLE);
    assign acceptPair     = EN_mult && RDY_mult;
    assign writesInFlight = |stageValid;
    assign clampedLen     = (blockRead_len > DEPTH_LEN) ? DEPTH_LEN : blockRead_len;
    assign fullProduct    = PROD_W'(mult_input0) * PROD_W'(mult_input1);

    // Fold the full product into the stored width before it enters the pipeline
    generate
        if (OUT_W >= PROD_W) begin : gZeroExtend
            assign storedValue = OUT_W'(fullProduct);
        end else begin : gNarrow
            logic overflow;
            assign overflow    = |fullProduct[PROD_W-1:OUT_W];
            assign storedValue = (mode_sat && overflow) ? '1 : fullProduct[OUT_W-1:0];
        end
    endgenerate

    // Write pointer advances once per accepted pair and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (acceptPair) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Product pipeline; the last stage drives the memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stageValid <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                stageData[i] <= '0;
                stageAddr[i] <= '0;
            end
        end else begin
            stageValid[0] <= acceptPair;
            if (acceptPair) begin
                stageData[0] <= storedValue;
                stageAddr[0] <= wr_ptr;
            end
            for (int i = 1; i < MULT_STAGES; i++) begin
                stageValid[i] <= stageValid[i-1];
                stageData[i]  <= stageData[i-1];
                stageAddr[i]  <= stageAddr[i-1];
            end
        end
    end

    assign EN_writeMem   = stageValid[MULT_STAGES-1];
    assign writeMem_addr = stageAddr[MULT_STAGES-1];
    assign writeMem_val  = stageData[MULT_STAGES-1];

    // Hold off readiness until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyArm <= 1'b0;
        end else begin
            readyArm <= 1'b1;
        end
    end

    // Block-read sequencer: latch the window, wait out pending writes, issue reads, drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            startAddr    <= '0;
            lenReg       <= '0;
            remaining    <= '0;
            issueLast    <= 1'b0;
            EN_readMem   <= 1'b0;
            readMem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN_blockRead && (blockRead_len != '0)) begin
                        startAddr <= blockRead_start;
                        lenReg    <= clampedLen;
                        if (acceptPair || writesInFlight) begin
                            state <= WAIT_WR;
                        end else begin
                            state        <= READ;
                            EN_readMem   <= 1'b1;
                            readMem_addr <= blockRead_start;
                            remaining    <= clampedLen - 1'b1;
                            issueLast    <= (clampedLen == ONE_LEN);
                        end
                    end
                end
                WAIT_WR: begin
                    if (!writesInFlight) begin
                        state        <= READ;
                        EN_readMem   <= 1'b1;
                        readMem_addr <= startAddr;
                        remaining    <= lenReg - 1'b1;
                        issueLast    <= (lenReg == ONE_LEN);
                    end
                end
                READ: begin
                    if (remaining != '0) begin
                        EN_readMem   <= 1'b1;
                        readMem_addr <= readMem_addr + 1'b1;
                        remaining    <= remaining - 1'b1;
                        issueLast    <= (remaining == ONE_LEN);
                    end else begin
                        EN_readMem <= 1'b0;
                        issueLast  <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (LAST_memVal) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track each issued read across the memory latency so VALID/LAST line up with the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe <= '0;
            lastPipe  <= '0;
        end else begin
            validPipe[0] <= EN_readMem;
            lastPipe[0]  <= EN_readMem && issueLast;
            for (int i = 1; i < READ_LAT; i++) begin
                validPipe[i] <= validPipe[i-1];
                lastPipe[i]  <= lastPipe[i-1];
            end
        end
    end

    assign VALID_memVal = validPipe[READ_LAT-1];
    assign LAST_memVal  = lastPipe[READ_LAT-1];
    assign memVal_data  = VALID_memVal ? readMem_val : '0;

endmodule

// File: doc/mult_mem_engine.md
# mult_mem_engine

Parametrised multiply-and-log engine with block readback. It accepts operand pairs, multiplies them in a configurable-depth pipeline and writes each product to sequential addresses of an external two-port memory, where the write pointer wraps. On request it streams a programmable window of stored products back out. It sits between the stimulus/compute side and the shared two-port memory wrapper: it drives port B for writes and port A for reads.

## Interface
- IN_W, 16, operand width (unsigned)
- OUT_W, 16, stored product width
- ADDR_W, 6, memory address width; DEPTH = 2^ADDR_W
- MULT_STAGES, 2, multiplier pipeline depth (≥1)
- READ_LAT, 1, memory read latency in cycles (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- EN_mult  in  1  operand pair valid
- mult_input0, mult_input1  in  IN_W  operands
- mode_sat  in  1  0 = truncate, 1 = saturate; sampled with each accepted pair
- RDY_mult  out  1  engine can accept a pair
- EN_writeMem  out  1  write strobe (memory cen = ~EN_writeMem)
- writeMem_addr  out  ADDR_W  write address
- writeMem_val  out  OUT_W  write data
- EN_blockRead  in  1  block-read request pulse
- blockRead_start  in  ADDR_W  first address of window
- blockRead_len  in  ADDR_W+1  beats requested
- EN_readMem  out  1  read strobe (memory cen = ~EN_readMem)
- readMem_addr  out  ADDR_W  read address
- readMem_val  in  OUT_W  memory read data
- VALID_memVal  out  1  memVal_data valid
- memVal_data  out  OUT_W  streamed product
- LAST_memVal  out  1  final beat of window
- wr_ptr  out  ADDR_W  next write address

## Operation
- Accept: an operand pair is accepted on a rising edge where EN_mult && RDY_mult. It gets address wr_ptr, and wr_ptr then increments modulo DEPTH. Later pairs overwrite old entries.
- Product: full unsigned product of 2·IN_W bits.
  - Truncate mode stores the low OUT_W bits.
  - Saturate mode stores all-ones if product > 2^OUT_W−1, else the product.
  - If OUT_W ≥ 2·IN_W, the product is zero-extended.
- Read FSM states: IDLE, WAIT_WR, READ, DRAIN.
  - IDLE: on EN_blockRead, latch start and len.
    - len = 0: request ignored, stay IDLE.
    - len > DEPTH: clamped to DEPTH.
    - Writes in flight: go to WAIT_WR. Otherwise go to READ.
  - WAIT_WR: stay until the multiplier pipeline is empty, then go to READ.
  - READ: each cycle, assert EN_readMem and issue readMem_addr = start+i mod DEPTH. After len issues, go to DRAIN.
  - DRAIN: wait until the last beat has been returned, then go to IDLE.
- EN_blockRead is ignored outside IDLE.
- RDY_mult = 1 only in IDLE. New pairs are never accepted while a read is pending or active, so there are no read/write address collisions.
- Reset mid-operation: pipeline flushed, FSM to IDLE, wr_ptr = 0. Memory contents are not cleared.

## Timing
- Reset values: RDY_mult, EN_writeMem, EN_readMem, VALID_memVal and LAST_memVal are 0; all addresses, data and wr_ptr are 0.
- RDY_mult rises on the first clk edge after rst_n deasserts.
- Write latency: a pair accepted at edge t produces EN_writeMem = 1 with its address and value during cycle t+MULT_STAGES. Back-to-back accepts give back-to-back writes.
- Read latency:
  - IDLE→READ (no writes in flight): the first EN_readMem is issued in the cycle after the request edge.
  - Each issue at cycle c gives VALID_memVal = 1 at c+READ_LAT, with memVal_data = readMem_val registered through.
  - LAST_memVal is asserted with the len-th beat only.
- RDY_mult returns to 1 in the cycle after the last VALID beat.
- EN_blockRead coincident with an accepting edge: the pair is accepted, and the FSM enters WAIT_WR.
- No bubbles inside a window: len beats arrive on consecutive cycles.

## Test plan
- Reset, then 5 back-to-back pairs (0,0)…(4,4) with defaults → EN_writeMem high for 5 consecutive cycles starting 2 cycles after the first accept; addr 0..4 get 0,1,4,9,16; wr_ptr = 5.
- Pair (300,300), mode_sat = 1 → stored 0xFFFF. Same pair with mode_sat = 0 → stored 0x5F90.
- After the first scenario, block read start = 0, len = 5 → EN_readMem for addr 0..4 on consecutive cycles; VALID beats 0,1,4,9,16 one cycle later; LAST on the 5th beat; RDY_mult low throughout, 1 the cycle after.
- Write 66 pairs (i,i) with i = 0..65 (truncate mode) → addr 0,1 hold 4096,4225; block read start = 62, len = 4 → beats 3844,3969,4096,4225 from addr 62,63,0,1; len = 100 → exactly 64 beats.
- Accept pair (7,7) and assert EN_blockRead (start = wr_ptr, len = 1) on the same edge → FSM in WAIT_WR for the pipeline duration; the single beat returns 49 with LAST = 1.
- rst_n low after 2 beats of a len = 5 read → all strobes, VALID and LAST drop to 0 asynchronously; after release the next write goes to addr 0.
